// File: rtl/accum_deskew_fifo.sv
// accum_deskew_fifo: realigns skewed systolic accumulator lanes into rows and buffers them in a FIFO
`timescale 1ns/1ps
module accum_deskew_fifo #(
  parameter int OC0   = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [32*OC0-1:0]   accum_in_chained,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*OC0-1:0]   ofmap_dat_chained,
  output logic                full,
  output logic                overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [32*OC0-1:0] aligned;
  logic              v_out;
  genvar g;
  // lane j arrives j cycles after lane 0, so it waits OC0-1-j stages to line up with the last lane
  for (g = 0; g < OC0; g++) begin : g_lane
    localparam int D = OC0 - 1 - g;
    if (D == 0) begin : g_pass
      assign aligned[32*g +: 32] = accum_in_chained[32*g +: 32];
    end else begin : g_dly
      logic [31:0] sr [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= accum_in_chained[32*g +: 32];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[32*g +: 32] = sr[D-1];
    end
  end
  if (OC0 == 1) begin : g_vnone
    assign v_out = in_valid;
  end else begin : g_vpipe
    logic [OC0-2:0] vp;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vp <= '0;
      end else if (en) begin
        vp[0] <= in_valid;
        for (int i = 1; i < OC0 - 1; i++) vp[i] <= vp[i-1];
      end
    end
    assign v_out = vp[OC0-2];
  end
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       cnt;
  logic [32*OC0-1:0] mem [DEPTH];
  logic              push, pop, wr;
  assign push = v_out & en;
  assign pop  = out_valid & out_ready;
  // a full FIFO still takes a row when the head leaves on the same edge
  assign wr   = push & (~full | pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= aligned;
  end
  assign out_valid         = cnt != '0;
  assign full              = cnt == (AW+1)'(DEPTH);
  assign ofmap_dat_chained = out_valid ? mem[rp] : '0;
endmodule
